// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a shadow XNOR Fibonacci LFSR to the incoming
// stream, declares lock after a run of correct predictions, then counts bit errors.
module prbs_checker #(
  parameter int           WIDTH       = 32,
  parameter logic [167:0] TAPS        = 168'h80200003,
  parameter int           LOCK_COUNT  = 64,
  parameter int           LOSS_WINDOW = 128,
  parameter int           LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear_counts,
  output logic        locked,
  output logic        error,
  output logic [31:0] err_count,
  output logic [31:0] bit_count,
  output logic [1:0]  state
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam int SEED_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
  logic [31:0]        err_count_q, err_count_d;
  logic [31:0]        bit_count_q, bit_count_d;
  logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;

  logic predicted;
  logic mismatch;
  logic lockup;

  assign predicted = ~^(sh_q & TAP_MASK);
  assign mismatch  = (in_bit != predicted);
  assign lockup    = &sh_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;

    if (in_valid) begin
      case (state_q)
        SEED: begin
          sh_d = {sh_q[WIDTH-2:0], in_bit};
          if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
            state_d     = VERIFY;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          sh_d = {sh_q[WIDTH-2:0], in_bit};
          // The all-ones register is the XNOR lockup state and predicts itself forever.
          if (lockup || mismatch) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
            state_d     = LOCKED;
            locked_d    = 1'b1;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          sh_d = {sh_q[WIDTH-2:0], predicted};
          if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
          if (mismatch) begin
            error_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 32'd1;
          end
          if (mismatch && (win_err_q == WERR_W'(LOSS_THRESH - 1))) begin
            state_d    = SEED;
            locked_d   = 1'b0;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_W'(LOSS_WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (mismatch) win_err_d = win_err_q + 1'b1;
          end
        end
        default: begin
          state_d  = SEED;
          locked_d = 1'b0;
        end
      endcase
    end

    if (clear_counts) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      sh_q        <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a driver feeds a 32-bit XNOR LFSR stream with
// directed bit flips and queues expectations; a monitor pops and compares them.
module tb_prbs_checker;

  localparam logic [31:0] GEN_TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic        error;
  logic [31:0] err_count;
  logic [31:0] bit_count;
  logic [1:0]  state;

  always #5 clk = ~clk;

  prbs_checker #(
    .WIDTH(32),
    .TAPS(168'h80200003),
    .LOCK_COUNT(64),
    .LOSS_WINDOW(128),
    .LOSS_THRESH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .clear_counts(clear_counts),
    .locked(locked),
    .error(error),
    .err_count(err_count),
    .bit_count(bit_count),
    .state(state)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [1:0]  st;
    logic        lk;
    logic        er;
    logic [31:0] ec;
    logic [31:0] bc;
  } exp_t;

  exp_t        exp_q[$];
  int          err_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          done = 1'b0;
  logic [31:0] gen = '0;
  int          nb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver helpers ----------------
  task automatic step(input logic v, input logic b, input logic clr);
    in_valid     = v;
    in_bit       = b;
    clear_counts = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic flip, input logic clr = 1'b0);
    gen = {gen[30:0], ~^(gen & GEN_TAPS)};
    nb++;
    step(1'b1, gen[0] ^ flip, clr);
    if (flip) err_q.push_back(cyc);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic lk,
                            input logic er, input int ec, input int bc);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.st   = st;
    e.lk   = lk;
    e.er   = er;
    e.ec   = 32'(ec);
    e.bc   = 32'(bc);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic v, input logic b);
    reset = 1'b1;
    step(v, b, 1'b0);
    reset = 1'b0;
    gen   = '0;
    nb    = 0;
    expect_out("reset", 2'd0, 1'b0, 1'b0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d at cycle %0d", nm, fld, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (error) begin
      if (err_q.size() == 0) begin
        chk("error_pulse", "unexpected", 32'd1, 32'd0);
      end else begin
        c = err_q.pop_front();
        chk("error_pulse", "cycle", 32'(cyc), 32'(c));
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk(e.name, "cycle", 32'(cyc), 32'(e.cyc));
      chk(e.name, "state", 32'(state), 32'(e.st));
      chk(e.name, "locked", 32'(locked), 32'(e.lk));
      chk(e.name, "error", 32'(error), 32'(e.er));
      chk(e.name, "err_count", err_count, e.ec);
      chk(e.name, "bit_count", bit_count, e.bc);
      $display("chk %s @%0d state=%0d locked=%0d error=%0d err=%0d bits=%0d",
               e.name, cyc, state, locked, error, err_count, bit_count);
    end
    if (done) begin
      chk("end", "pending_errors", 32'(err_q.size()), 32'd0);
      chk("end", "pending_expects", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic nxt;

    // Continuous stream: lock after bit 96, 9904 checked bits by bit 10000.
    do_reset(1'b0, 1'b0);
    repeat (95) send(1'b0);
    expect_out("pre_lock", 2'd1, 1'b0, 1'b0, 0, 0);
    send(1'b0);
    expect_out("lock_96", 2'd2, 1'b1, 1'b0, 0, 0);
    while (nb < 10000) send(1'b0);
    expect_out("run_10000", 2'd2, 1'b1, 1'b0, 0, 9904);

    // Single flipped bit: one pulse, lock held, stream stays in step.
    send(1'b1);
    expect_out("single_flip", 2'd2, 1'b1, 1'b1, 1, 9905);
    repeat (200) send(1'b0);
    expect_out("after_flip", 2'd2, 1'b1, 1'b0, 1, 10105);

    // Eight errors in one window (bits 97,99..111): lock lost on the 8th.
    do_reset(1'b0, 1'b0);
    repeat (96) send(1'b0);
    for (int k = 1; k <= 8; k++) begin
      send(1'b1);
      if (k < 8) begin
        expect_out("loss_flip", 2'd2, 1'b1, 1'b1, k, nb - 96);
        send(1'b0);
      end
    end
    expect_out("loss_8th", 2'd0, 1'b0, 1'b1, 8, 15);
    repeat (95) send(1'b0);
    expect_out("relock_pre", 2'd1, 1'b0, 1'b0, 8, 15);
    send(1'b0);
    expect_out("relock", 2'd2, 1'b1, 1'b0, 8, 15);

    // Seven errors ending on a window's last bit (224), seven more opening the next.
    do_reset(1'b0, 1'b0);
    repeat (96) send(1'b0);
    while (nb < 237) begin
      nxt = ((nb + 1 >= 212) && (nb + 1 <= 224) && ((nb + 1) % 2 == 0)) ||
            ((nb + 1 >= 225) && ((nb + 1) % 2 == 1));
      send(nxt);
    end
    expect_out("two_windows_mid", 2'd2, 1'b1, 1'b1, 14, 141);
    while (nb < 400) send(1'b0);
    expect_out("two_windows", 2'd2, 1'b1, 1'b0, 14, 304);

    // Constant-1 stream parks in VERIFY and never counts.
    do_reset(1'b0, 1'b0);
    repeat (32) step(1'b1, 1'b1, 1'b0);
    expect_out("const1_seeded", 2'd1, 1'b0, 1'b0, 0, 0);
    repeat (968) step(1'b1, 1'b1, 1'b0);
    expect_out("const1_1000", 2'd1, 1'b0, 1'b0, 0, 0);

    // Alternating valid: lock after bit 96 at cycle 191 since reset.
    do_reset(1'b0, 1'b0);
    repeat (95) begin
      send(1'b0);
      idle();
    end
    expect_out("toggle_pre", 2'd1, 1'b0, 1'b0, 0, 0);
    send(1'b0);
    expect_out("toggle_lock", 2'd2, 1'b1, 1'b0, 0, 0);
    idle();
    repeat (10) begin
      send(1'b0);
      idle();
    end
    expect_out("toggle_run", 2'd2, 1'b1, 1'b0, 0, 10);
    send(1'b1, 1'b1);
    expect_out("clear_vs_error", 2'd2, 1'b1, 1'b1, 0, 0);
    idle();
    send(1'b0);
    expect_out("after_clear", 2'd2, 1'b1, 1'b0, 0, 1);
    send(1'b1);
    expect_out("err_after_clear", 2'd2, 1'b1, 1'b1, 1, 2);
    step(1'b0, 1'b0, 1'b1);
    expect_out("clear_idle", 2'd2, 1'b1, 1'b0, 0, 0);

    // Reset while locked, with a mismatching bit on the reset edge.
    nxt = ~^(gen & GEN_TAPS);
    do_reset(1'b1, ~nxt);
    step(1'b0, 1'b0, 1'b0);
    expect_out("post_reset", 2'd0, 1'b0, 1'b0, 0, 0);

    done = 1'b1;
  end

endmodule
